cipher_stream_unit: RTL and testbench

//  Parametrised streaming XOR/permutation cipher. Carries DW-bit beats through a 2-stage

---
 rtl/cipher_stream_pkg.sv | 36 +++
 rtl/cipher_key_sched.sv | 82 ++++++++
 rtl/cipher_stream_unit.sv | 119 +++++++++++
 tb/tb_cipher_stream_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_stream_pkg.sv
// Shared types and helpers for the streaming XOR/rotate cipher: mode enum,
// width-generic rotate functions and the key-index width helper.
package cipher_stream_pkg;

  typedef enum logic {
    CIPH_ENC = 1'b0,
    CIPH_DEC = 1'b1
  } cipher_mode_e;

  localparam int unsigned ROT_MAXW  = 64;
  localparam int unsigned ROT_IW    = $clog2(ROT_MAXW);
  localparam int unsigned ROT_CNT_W = 4;

  function automatic int unsigned kidx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Rotate the low w bits of x left by r; bits at or above w come back as zero.
  function automatic logic [ROT_MAXW-1:0] rotl(input logic [ROT_MAXW-1:0] x,
                                               input int unsigned w,
                                               input int unsigned r);
    logic [ROT_MAXW-1:0] y;
    y = '0;
    for (int unsigned i = 0; i < ROT_MAXW; i++) begin
      if (i < w) y[ROT_IW'((i + r) % w)] = x[ROT_IW'(i)];
    end
    return y;
  endfunction

  function automatic logic [ROT_MAXW-1:0] rotr(input logic [ROT_MAXW-1:0] x,
                                               input int unsigned w,
                                               input int unsigned r);
    return rotl(x, w, (w - (r % w)) % w);
  endfunction

endpackage

// File: rtl/cipher_key_sched.sv
// Key bank, cipher mode and rotation config, plus the per-beat key index
// schedule. Config is only accepted while the pipeline is empty.
module cipher_key_sched
  import cipher_stream_pkg::*;
#(
  parameter  int unsigned            DW       = 8,
  parameter  int unsigned            NKEYS    = 3,
  parameter  logic [NKEYS*DW-1:0]    KEY_INIT = '0,
  localparam int unsigned            KW       = kidx_width(NKEYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_load_i,
  input  logic [NKEYS*DW-1:0]    cfg_key_i,
  input  logic [ROT_CNT_W-1:0]   cfg_rot_i,
  input  logic                   cfg_mode_i,
  input  logic                   busy_i,
  input  logic                   accept_i,
  output logic [NKEYS*DW-1:0]    key_bank_o,
  output logic [KW-1:0]          key_idx_o,
  output cipher_mode_e           mode_o,
  output logic                   cfg_err_o
);

  logic [NKEYS*DW-1:0]  bank_q, bank_d;
  cipher_mode_e         mode_q, mode_d;
  logic [ROT_CNT_W-1:0] rot_q,  rot_d;
  logic [KW-1:0]        idx_q,  idx_d;
  logic [ROT_CNT_W-1:0] cnt_q,  cnt_d;
  logic                 err_q,  err_d;

  // NOTE: every variable gets its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bank_d = bank_q;
    mode_d = mode_q;
    rot_d  = rot_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    err_d  = cfg_load_i & busy_i;

    if (cfg_load_i && !busy_i) begin
      bank_d = cfg_key_i;
      mode_d = cipher_mode_e'(cfg_mode_i);
      rot_d  = cfg_rot_i;
      idx_d  = '0;
      cnt_d  = '0;
    end else if (accept_i && rot_q != '0) begin
      if (cnt_q == rot_q - 4'd1) begin
        cnt_d = '0;
        idx_d = (idx_q == KW'(NKEYS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the key bank is a few flops, not a RAM, so it takes a reset value like any other state.
  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= KEY_INIT;
      mode_q <= CIPH_ENC;
      rot_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      mode_q <= mode_d;
      rot_q  <= rot_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign key_bank_o = bank_q;
  assign key_idx_o  = idx_q;
  assign mode_o     = mode_q;
  assign cfg_err_o  = err_q;

endmodule

// File: rtl/cipher_stream_unit.sv
// Two-stage valid/ready cipher pipe: stage 1 captures the beat and its key
// index, stage 2 holds the transformed beat presented to the sink.
module cipher_stream_unit
  import cipher_stream_pkg::*;
#(
  parameter int unsigned         DW       = 8,
  parameter int unsigned         NKEYS    = 3,
  parameter int unsigned         ROT_BITS = 3,
  parameter logic [NKEYS*DW-1:0] KEY_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [NKEYS*DW-1:0]  cfg_key,
  input  logic [ROT_CNT_W-1:0] cfg_rot,
  input  logic                 cfg_mode,
  output logic                 cfg_err,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW-1:0]        m_data,
  output logic                 busy
);

  localparam int unsigned KW = kidx_width(NKEYS);

  logic [NKEYS*DW-1:0] key_bank;
  logic [KW-1:0]       key_idx;
  cipher_mode_e        mode;
  logic [DW-1:0]       keys [NKEYS];
  logic [DW-1:0]       key_sel;
  logic [DW-1:0]       xf;

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q,  s1_data_d;
  logic [KW-1:0] s1_idx_q,   s1_idx_d;
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s2_data_q,  s2_data_d;

  logic s2_load, s1_move, s1_load, accept;

  assign s2_load = !s2_valid_q || m_ready;
  assign s1_move = s1_valid_q && s2_load;
  assign s1_load = !s1_valid_q || s1_move;
  // A load request owns the cycle so the new config never races a beat in.
  assign s_ready = s1_load && !cfg_load;
  assign accept  = s_valid && s_ready;
  assign busy    = s1_valid_q || s2_valid_q;

  cipher_key_sched #(
    .DW       (DW),
    .NKEYS    (NKEYS),
    .KEY_INIT (KEY_INIT)
  ) u_key_sched (
    .clk        (clk),
    .rst        (rst),
    .cfg_load_i (cfg_load),
    .cfg_key_i  (cfg_key),
    .cfg_rot_i  (cfg_rot),
    .cfg_mode_i (cfg_mode),
    .busy_i     (busy),
    .accept_i   (accept),
    .key_bank_o (key_bank),
    .key_idx_o  (key_idx),
    .mode_o     (mode),
    .cfg_err_o  (cfg_err)
  );

  always_comb begin
    for (int i = 0; i < NKEYS; i++) keys[i] = key_bank[i*DW +: DW];
  end

  always_comb begin
    key_sel = keys[s1_idx_q];
    if (mode == CIPH_DEC) xf = DW'(rotr(ROT_MAXW'(s1_data_q ^ key_sel), DW, ROT_BITS));
    else                  xf = DW'(rotl(ROT_MAXW'(s1_data_q), DW, ROT_BITS)) ^ key_sel;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_idx_d   = s1_idx_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_data_d = xf;
    end
    if (s1_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_data_d = s_data;
        s1_idx_d  = key_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign m_valid = s2_valid_q;
  assign m_data  = s2_data_q;

endmodule

// File: tb/tb_cipher_stream_unit.sv
// Directed bench for cipher_stream_unit with a beat-level reference model
// checked every cycle on the falling edge, plus hand-computed literals.
module tb_cipher_stream_unit;

  localparam int          DW    = 8;
  localparam int          NK    = 3;
  localparam logic [23:0] KINIT = 24'h123456;
  localparam logic [23:0] KSTD  = 24'h0F3CA5;

  logic        clk, rst;
  logic        cfg_load, cfg_mode, cfg_err;
  logic [23:0] cfg_key;
  logic [3:0]  cfg_rot;
  logic        s_valid, s_ready, m_valid, m_ready, busy;
  logic [7:0]  s_data, m_data;

  cipher_stream_unit #(.DW(DW), .NKEYS(NK), .ROT_BITS(3), .KEY_INIT(KINIT)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_rot(cfg_rot),
    .cfg_mode(cfg_mode), .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: beats in flight with their accept cycle, plus config.
  typedef struct { logic [7:0] data; int cyc; } beat_t;
  beat_t       exp_q[$];
  logic [7:0]  got[$];
  logic [23:0] m_bank = KINIT;
  int          m_rot  = 0;
  logic        m_mode = 1'b0;
  int          n_acc  = 0;
  bit          err_exp = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;
  int          cyc = 0;

  function automatic logic [7:0] model_out(input logic [7:0] x);
    int         idx;
    int         v;
    logic [7:0] k;
    idx = (m_rot == 0) ? 0 : (n_acc / m_rot) % NK;
    k   = m_bank[idx*8 +: 8];
    if (!m_mode) begin
      v = x;
      return 8'(((v << 3) | (v >> 5)) ^ k);
    end
    v = x ^ k;
    return 8'((v >> 3) | (v << 5));
  endfunction

  always @(negedge clk) begin
    bit exp_mv, exp_rdy;
    beat_t b;
    cyc++;
    if (!rst) begin
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_m_data", m_data, 0);
      exp_q.delete();
      m_bank = KINIT; m_rot = 0; m_mode = 1'b0; n_acc = 0;
      err_exp = 1'b0; prev_stall = 1'b0;
    end else begin
      exp_mv  = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
      exp_rdy = !cfg_load && (exp_q.size() < 2 || m_ready);
      check("m_valid", m_valid, exp_mv);
      check("busy", busy, exp_q.size() != 0);
      check("s_ready", s_ready, exp_rdy);
      check("cfg_err", cfg_err, err_exp);
      if (exp_mv && m_valid) check("m_data", m_data, exp_q[0].data);
      if (prev_stall) begin
        check("stall_hold_valid", m_valid, 1);
        check("stall_hold_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      err_exp    = cfg_load && exp_q.size() != 0;
      if (cfg_load && exp_q.size() == 0) begin
        m_bank = cfg_key; m_rot = cfg_rot; m_mode = cfg_mode; n_acc = 0;
      end
      if (exp_mv && m_ready) begin
        got.push_back(exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (s_valid && exp_rdy) begin
        b.data = model_out(s_data);
        b.cyc  = cyc;
        exp_q.push_back(b);
        n_acc++;
      end
    end
  end

  task automatic send_beat(input logic [7:0] x);
    int n = 0;
    s_valid = 1'b1;
    s_data  = x;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 100);
    if (!s_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] key, input logic [3:0] rot, input logic mode);
    cfg_key  = key;
    cfg_rot  = rot;
    cfg_mode = mode;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] e_rot1 [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hA5};
    logic [7:0] e_rot2 [4] = '{8'hA5, 8'hA5, 8'h3C, 8'h3C};
    logic [7:0] e_bp   [4] = '{8'hAD, 8'hB5, 8'hBD, 8'h85};
    logic [7:0] ct [256];
    int errs;

    rst = 1'b0; cfg_load = 1'b0; cfg_key = '0; cfg_rot = '0; cfg_mode = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1);
    @(posedge clk); #1;

    // Encrypt / decrypt single beats with a fixed key.
    do_load(KSTD, 4'd0, 1'b0); got.delete();
    send_beat(8'h01); drain();
    check("enc_01", got[0], 8'hAD);
    do_load(KSTD, 4'd0, 1'b1); got.delete();
    send_beat(8'hAD); drain();
    check("dec_AD", got[0], 8'h01);

    // Key rotation every beat, then every second beat.
    do_load(KSTD, 4'd1, 1'b0); got.delete();
    repeat (4) send_beat(8'h00);
    drain();
    for (int i = 0; i < 4; i++) check($sformatf("rot1_%0d", i), got[i], e_rot1[i]);
    do_load(KSTD, 4'd2, 1'b0); got.delete();
    repeat (4) send_beat(8'h00);
    drain();
    for (int i = 0; i < 4; i++) check($sformatf("rot2_%0d", i), got[i], e_rot2[i]);

    // Backpressure: sink stalls for 5 cycles during a 4-beat burst.
    do_load(KSTD, 4'd0, 1'b0); got.delete();
    m_ready = 1'b0;
    fork
      for (int i = 1; i <= 4; i++) send_beat(8'(i));
      begin repeat (5) @(posedge clk); #1; m_ready = 1'b1; end
    join
    drain();
    check("bp_count", got.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("bp_%0d", i), got[i], e_bp[i]);

    // Load while busy is ignored and flagged for one cycle.
    got.delete();
    m_ready = 1'b0;
    send_beat(8'h01); send_beat(8'h02);
    do_load(24'h112233, 4'd0, 1'b0);
    check("err_pulse", cfg_err, 1);
    @(posedge clk); #1;
    check("err_clear", cfg_err, 0);
    m_ready = 1'b1;
    drain();
    check("busy_load_old0", got[0], 8'hAD);
    check("busy_load_old1", got[1], 8'hB5);

    // Load while idle with a beat waiting: beat held one cycle, uses new key0.
    got.delete();
    cfg_key = 24'h112233; cfg_rot = 4'd0; cfg_mode = 1'b0; cfg_load = 1'b1;
    s_valid = 1'b1; s_data = 8'h00;
    @(negedge clk);
    check("load_blocks_ready", s_ready, 0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    send_beat(8'h00); drain();
    check("new_key0", got[0], 8'h33);

    // Full byte round trip through encrypt then decrypt, rotating keys.
    do_load(KSTD, 4'd2, 1'b0); got.delete();
    for (int i = 0; i < 256; i++) send_beat(8'(i));
    drain();
    for (int i = 0; i < 256; i++) ct[i] = got[i];
    do_load(KSTD, 4'd2, 1'b1); got.delete();
    for (int i = 0; i < 256; i++) send_beat(ct[i]);
    drain();
    check("rt_count", got.size(), 256);
    errs = 0;
    for (int i = 0; i < 256; i++) if (got[i] !== 8'(i)) errs++;
    check("rt_errs", errs, 0);

    // Reset with two beats in flight.
    do_load(KSTD, 4'd0, 1'b0);
    m_ready = 1'b0;
    send_beat(8'h01); send_beat(8'h02);
    rst = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1; m_ready = 1'b1; got.delete();
    send_beat(8'h01); drain();
    check("post_rst_kinit", got[0], 8'h5E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
